mux4_bus_arbiter: RTL and testbench

- Round-robin arbiter that shares one 32-bit result bus among four requesters.
- Drives the 2-bit select of the 4-to-1 32-bit datapath mux and produces the muxed output word.
- Frames each grant as a burst with a valid/ready handshake towards a single consumer, for example the register-file write port or a memory stage.
- Sits between the requesting functional units and the shared write-back bus.

---
 rtl/mux4_bus_arbiter.sv | 122 ++++++++++++
 tb/tb_mux4_bus_arbiter.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/mux4_bus_arbiter.sv
// Round-robin arbiter for four requesters sharing one WIDTH-bit result bus, with
// burst framing over a valid/ready handshake. Optional: MUX4_ARB_BACK2BACK_EN (no idle bubble).
module mux4_bus_arbiter #(
    parameter int WIDTH     = 32,
    parameter int MAX_BURST = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [3:0]       req,
    input  logic [3:0]       last,
    input  logic [WIDTH-1:0] data0,
    input  logic [WIDTH-1:0] data1,
    input  logic [WIDTH-1:0] data2,
    input  logic [WIDTH-1:0] data3,
    output logic [3:0]       gnt,
    output logic [1:0]       sel,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             busy
);

    localparam logic [3:0] MAXB = 4'(MAX_BURST);

    typedef enum logic {IDLE, GRANT} state_t;

    state_t     state;
    logic [1:0] rr_ptr;
    logic [3:0] beat_cnt;
    logic [3:0] cnt_inc;
    logic [1:0] next_ptr;
    logic       accept;
    logic       release_now;
    logic [2:0] idle_pick;

    // Returns {found, index}: first set bit of r starting at ptr, wrapping mod 4.
    function automatic logic [2:0] rr_pick(input logic [3:0] r, input logic [1:0] ptr);
        logic [2:0] res;
        logic [1:0] idx;
        res = 3'b000;
        for (int k = 3; k >= 0; k--) begin
            idx = ptr + 2'(k);
            if (r[idx]) res = {1'b1, idx};
        end
        return res;
    endfunction

    always_comb begin
        case (sel)
            2'd0:    out_data = data0;
            2'd1:    out_data = data1;
            2'd2:    out_data = data2;
            default: out_data = data3;
        endcase
    end

    assign out_valid   = (state == GRANT) && req[sel];
    assign accept      = out_valid && out_ready;
    assign cnt_inc     = (beat_cnt == MAXB) ? beat_cnt : beat_cnt + 4'd1;
    assign next_ptr    = sel + 2'd1;
    assign idle_pick   = rr_pick(req, rr_ptr);
    // An abandoned burst (req dropped) releases without a beat being taken.
    assign release_now = (state == GRANT) &&
                         (!req[sel] || (accept && (last[sel] || cnt_inc == MAXB)));

`ifdef MUX4_ARB_BACK2BACK_EN
    logic [2:0] b2b_pick;
    // Search starts past the releasing requester, so it only wins when alone.
    assign b2b_pick = rr_pick(req, next_ptr);
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            gnt      <= 4'b0000;
            sel      <= 2'd0;
            rr_ptr   <= 2'd0;
            beat_cnt <= 4'd0;
            busy     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (idle_pick[2]) begin
                        sel      <= idle_pick[1:0];
                        gnt      <= 4'b0001 << idle_pick[1:0];
                        beat_cnt <= 4'd0;
                        state    <= GRANT;
                        busy     <= 1'b1;
                    end
                end
                GRANT: begin
                    if (release_now) begin
                        rr_ptr   <= next_ptr;
                        beat_cnt <= 4'd0;
`ifdef MUX4_ARB_BACK2BACK_EN
                        if (b2b_pick[2]) begin
                            sel <= b2b_pick[1:0];
                            gnt <= 4'b0001 << b2b_pick[1:0];
                        end else begin
                            gnt   <= 4'b0000;
                            state <= IDLE;
                            busy  <= 1'b0;
                        end
`else
                        gnt   <= 4'b0000;
                        state <= IDLE;
                        busy  <= 1'b0;
`endif
                    end else if (accept) begin
                        beat_cnt <= cnt_inc;
                    end
                end
                default: begin
                    state <= IDLE;
                    gnt   <= 4'b0000;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mux4_bus_arbiter.sv
// Randomized burst traffic against a transaction-level arbiter model; accepted beats
// are checked by a scoreboard monitor, grant/busy/valid by per-cycle checks.
module tb_mux4_bus_arbiter;

    localparam int W    = 32;
    localparam int MAXB = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic [3:0]   req, last;
    logic [W-1:0] data0, data1, data2, data3;
    logic [3:0]   gnt;
    logic [1:0]   sel;
    logic [W-1:0] out_data;
    logic         out_valid, out_ready, busy;

    int tests = 0;
    int fails = 0;

    typedef struct {
        int           idx;
        logic [W-1:0] d;
    } beat_t;
    beat_t exp_q[$];

    // Burst sources: rem = beats left in the current burst, word = word on offer.
    int           rem [4];
    logic [W-1:0] word[4];

    // Reference model: who owns the bus, where the rotation resumes, beats taken.
    bit m_gr;
    int m_own, m_ptr, m_cnt;
    bit run_mon = 1'b0;

    mux4_bus_arbiter #(.WIDTH(W), .MAX_BURST(MAXB)) dut (
        .clk(clk), .rst(rst), .req(req), .last(last),
        .data0(data0), .data1(data1), .data2(data2), .data3(data3),
        .gnt(gnt), .sel(sel), .out_data(out_data), .out_valid(out_valid),
        .out_ready(out_ready), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int pick(input logic [3:0] r, input int ptr);
        for (int k = 0; k < 4; k++)
            if (r[(ptr + k) % 4]) return (ptr + k) % 4;
        return -1;
    endfunction

    task automatic drive_inputs();
        for (int i = 0; i < 4; i++) begin
            if (rem[i] == 0 && $urandom_range(0, 2) == 0) begin
                rem[i]  = $urandom_range(1, 6);
                word[i] = $urandom;
            end else if (rem[i] > 0 && $urandom_range(0, 39) == 0) begin
                rem[i] = 0;
            end
            req[i]  = (rem[i] != 0);
            last[i] = (rem[i] == 1);
        end
        data0     = word[0];
        data1     = word[1];
        data2     = word[2];
        data3     = word[3];
        out_ready = ($urandom_range(0, 3) != 0);
    endtask

    // Advance the model across the coming clock edge using the inputs just driven.
    task automatic model_step();
        bit acc, rel;
        int nx;
        beat_t b;
        if (!m_gr) begin
            nx = pick(req, m_ptr);
            if (nx >= 0) begin
                m_gr  = 1'b1;
                m_own = nx;
                m_cnt = 0;
            end
        end else begin
            acc = req[m_own] && out_ready;
            rel = !req[m_own];
            if (acc) begin
                b.idx = m_own;
                b.d   = word[m_own];
                exp_q.push_back(b);
                m_cnt++;
                if (last[m_own] || m_cnt == MAXB) rel = 1'b1;
                rem[m_own]--;
                word[m_own] = $urandom;
            end
            if (rel) begin
                m_ptr = (m_own + 1) % 4;
                m_gr  = 1'b0;
`ifdef MUX4_ARB_BACK2BACK_EN
                nx = pick(req, m_ptr);
                if (nx >= 0) begin
                    m_gr  = 1'b1;
                    m_own = nx;
                    m_cnt = 0;
                end
`endif
            end
        end
    endtask

    // Scoreboard monitor: every beat the DUT hands over must match the next expected one.
    always begin
        beat_t b;
        @(negedge clk);
        #2;
        if (run_mon && !rst && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_beat: sel=%0d data=%h, none expected", sel, out_data);
            end else begin
                b = exp_q.pop_front();
                chk("beat_sel", 32'(sel), 32'(b.idx));
                chk("beat_data", out_data, b.d);
            end
        end
    end

    initial begin
        rst       = 1'b1;
        req       = 4'b1111;
        last      = 4'b0000;
        out_ready = 1'b0;
        data0 = 32'h11111111; data1 = 32'h22222222;
        data2 = 32'h33333333; data3 = 32'h44444444;
        for (int i = 0; i < 4; i++) begin
            rem[i]  = 0;
            word[i] = '0;
        end
        m_gr = 1'b0; m_own = 0; m_ptr = 0; m_cnt = 0;

        repeat (3) begin
            @(negedge clk);
            chk("rst_gnt", gnt, 4'b0000);
            chk("rst_sel", sel, 2'd0);
            chk("rst_valid", out_valid, 1'b0);
            chk("rst_busy", busy, 1'b0);
            chk("rst_data", out_data, 32'h11111111);
        end
        rst = 1'b0;
        @(negedge clk);
        chk("first_gnt", gnt, 4'b0001);
        chk("first_sel", sel, 2'd0);
        chk("first_busy", busy, 1'b1);
        rst = 1'b1;
        #1;
        chk("async_rst_gnt", gnt, 4'b0000);
        chk("async_rst_valid", out_valid, 1'b0);

        req = 4'b0000;
        @(negedge clk);
        rst     = 1'b0;
        run_mon = 1'b1;
        repeat (3000) begin
            @(negedge clk);
            chk("gnt", gnt, m_gr ? (32'd1 << m_own) : 32'd0);
            chk("busy", busy, m_gr);
            if (m_gr) chk("sel", sel, 32'(m_own));
            drive_inputs();
            #1;
            chk("out_valid", out_valid, m_gr && req[m_own]);
            model_step();
        end
        #5;
        run_mon = 1'b0;
        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);

        // Reset in the middle of a held burst must drop the grant and restart rotation at 0.
        out_ready = 1'b0;
        req       = 4'b1111;
        last      = 4'b0000;
        for (int c = 0; c < 20 && gnt == 4'b0000; c++) @(negedge clk);
        chk("midburst_granted", 32'(gnt != 4'b0000), 32'd1);
        rst = 1'b1;
        #1;
        chk("midburst_rst_gnt", gnt, 4'b0000);
        chk("midburst_rst_valid", out_valid, 1'b0);
        chk("midburst_rst_busy", busy, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_gnt", gnt, 4'b0001);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
